// File: rtl/uart_rx_hex_display_if.sv
// uart_rx_hex_display_if: receiver-side strobes in, digit and LED outputs back
interface uart_rx_hex_display_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic        show_count;
  logic        clear;
  logic [23:0] hex_digits;
  logic [5:0]  digit_en;
  logic        act_led;
  logic        err_led;
  modport master (
    output rx_data, rx_valid, rx_err, show_count, clear,
    input  hex_digits, digit_en, act_led, err_led
  );
  modport slave (
    input  rx_data, rx_valid, rx_err, show_count, clear,
    output hex_digits, digit_en, act_led, err_led
  );
endinterface

// File: rtl/uart_rx_hex_display.sv
// uart_rx_hex_display: byte history, rx/error counters and LEDs for six hex digits
module uart_rx_hex_display #(
  parameter int CLK_HZ = 50000000,
  parameter int ACT_MS = 50,
  parameter int CNT_W  = 16
) (
  input logic                  clk,
  input logic                  rst,
  uart_rx_hex_display_if.slave bus
);
  localparam int ACT_RAW    = (CLK_HZ / 1000) * ACT_MS;
  localparam int ACT_CYCLES = ACT_RAW < 1 ? 1 : ACT_RAW;
  localparam int AW         = $clog2(ACT_CYCLES + 1);
  typedef enum logic [1:0] {EMPTY, ONE, TWO, FULL} fill_t;
  fill_t            fill, fill_nx;
  logic [7:0]       b0, b1, b2, b0_nx, b1_nx, b2_nx;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_nx;
  logic [7:0]       err_cnt, err_cnt_nx;
  logic [AW-1:0]    act_cnt, act_cnt_nx;
  logic             err_nx, acc, er;
  logic [23:0]      hex_nx;
  logic [5:0]       en_nx;
  // Next state of history, counters and one-shot; outputs derive from next state so they land with it
  always_comb begin
    acc         = bus.rx_valid & ~bus.rx_err;
    er          = bus.rx_valid & bus.rx_err;
    fill_nx     = acc && fill != FULL ? fill_t'(fill + 2'd1) : fill;
    b0_nx       = acc ? bus.rx_data : b0;
    b1_nx       = acc ? b0 : b1;
    b2_nx       = acc ? b1 : b2;
    byte_cnt_nx = acc ? byte_cnt + 1'b1 : byte_cnt;
    err_cnt_nx  = er && err_cnt != 8'hff ? err_cnt + 8'd1 : err_cnt;
    err_nx      = bus.err_led | er;
    act_cnt_nx  = acc ? AW'(ACT_CYCLES) : act_cnt != '0 ? act_cnt - 1'b1 : act_cnt;
    hex_nx      = bus.show_count ? {err_cnt_nx, byte_cnt_nx[15:0]} : {b2_nx, b1_nx, b0_nx};
    en_nx       = bus.show_count ? 6'h3f :
                  {{2{fill_nx == FULL}}, {2{fill_nx >= TWO}}, {2{fill_nx != EMPTY}}};
  end
  // State and registered outputs; clear behaves exactly like rst and drops a same-cycle byte
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      fill           <= EMPTY;
      b0             <= '0;
      b1             <= '0;
      b2             <= '0;
      byte_cnt       <= '0;
      err_cnt        <= '0;
      act_cnt        <= '0;
      bus.err_led    <= 1'b0;
      bus.hex_digits <= '0;
      bus.digit_en   <= '0;
      bus.act_led    <= 1'b0;
    end else begin
      fill           <= fill_nx;
      b0             <= b0_nx;
      b1             <= b1_nx;
      b2             <= b2_nx;
      byte_cnt       <= byte_cnt_nx;
      err_cnt        <= err_cnt_nx;
      act_cnt        <= act_cnt_nx;
      bus.err_led    <= err_nx;
      bus.hex_digits <= hex_nx;
      bus.digit_en   <= en_nx;
      bus.act_led    <= act_cnt_nx != '0;
    end
  end
endmodule

// File: tb/tb_uart_rx_hex_display.sv
// tb_uart_rx_hex_display: queue-based model compared every cycle plus literal spot checks
module tb_uart_rx_hex_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;
  uart_rx_hex_display_if bus ();
  uart_rx_hex_display #(.CLK_HZ(1000), .ACT_MS(5), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0]  q[$];
  int          m_cnt = 0, m_err = 0, m_act = 0;
  logic        m_led = 1'b0;
  logic [23:0] e_hex = '0;
  logic [5:0]  e_en = '0;
  logic        e_act = 1'b0;
  // Model: history as a 3-deep queue, counters as integers, outputs valid after each edge
  always @(posedge clk) begin
    if (rst || bus.clear) begin
      q.delete();
      m_cnt = 0; m_err = 0; m_act = 0; m_led = 1'b0;
      e_hex = '0; e_en = '0; e_act = 1'b0;
    end else begin
      if (bus.rx_valid && !bus.rx_err) begin
        q.push_front(bus.rx_data);
        if (q.size() > 3) void'(q.pop_back());
        m_cnt = (m_cnt + 1) % 65536;
        m_act = 5;
      end else if (m_act > 0) m_act = m_act - 1;
      if (bus.rx_valid && bus.rx_err) begin
        if (m_err < 255) m_err = m_err + 1;
        m_led = 1'b1;
      end
      e_act = m_act != 0;
      if (bus.show_count) begin
        e_hex = {m_err[7:0], m_cnt[15:0]};
        e_en  = 6'h3f;
      end else begin
        e_hex = '0;
        e_en  = '0;
        for (int i = 0; i < q.size(); i++) begin
          e_hex[8*i +: 8] = q[i];
          e_en[2*i +: 2]  = 2'b11;
        end
      end
    end
  end
  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  // Cycle compare against the model away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("hex_digits", bus.hex_digits, e_hex);
      check("digit_en", {18'd0, bus.digit_en}, {18'd0, e_en});
      check("act_led", {23'd0, bus.act_led}, {23'd0, e_act});
      check("err_led", {23'd0, bus.err_led}, {23'd0, m_led});
    end
  end
  task automatic step(input logic v, input logic e, input logic [7:0] d);
    bus.rx_valid = v;
    bus.rx_err   = e;
    bus.rx_data  = d;
    @(posedge clk);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_err   = 1'b0;
  endtask
  task automatic lit(input string name, input logic [23:0] hx, input logic [5:0] en, input logic a, input logic el);
    check({name, ".hex"}, bus.hex_digits, hx);
    check({name, ".en"}, {18'd0, bus.digit_en}, {18'd0, en});
    check({name, ".act"}, {23'd0, bus.act_led}, {23'd0, a});
    check({name, ".err"}, {23'd0, bus.err_led}, {23'd0, el});
  endtask
  task automatic count_act(input string name, input int exp);
    int n = 0;
    while (bus.act_led && n < 30) begin
      step(1'b0, 1'b0, 8'h00);
      n++;
    end
    check(name, 24'(n), 24'(exp));
  endtask
  initial begin
    bus.rx_data = '0; bus.rx_valid = 1'b0; bus.rx_err = 1'b0;
    bus.show_count = 1'b0; bus.clear = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (10) step(1'b0, 1'b0, 8'h00);
    lit("reset_idle", 24'h000000, 6'b000000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hEE);
    lit("err_no_valid", 24'h000000, 6'b000000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h3A);
    lit("first_byte", 24'h00003A, 6'b000011, 1'b1, 1'b0);
    foreach (q[i]) ;
    step(1'b1, 1'b0, 8'h12);
    step(1'b1, 1'b0, 8'h34);
    step(1'b1, 1'b0, 8'h56);
    step(1'b1, 1'b0, 8'h78);
    lit("history_full", 24'h345678, 6'b111111, 1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h9A);
    count_act("act_single", 5);
    step(1'b1, 1'b0, 8'hBC);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'hDE);
    count_act("act_retrigger", 5);
    lit("after_act", 24'h9ABCDE, 6'b111111, 1'b0, 1'b0);
    bus.clear = 1'b1;
    step(1'b1, 1'b0, 8'h99);
    bus.clear = 1'b0;
    lit("clear_drop", 24'h000000, 6'b000000, 1'b0, 1'b0);
    bus.show_count = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    lit("count_zero", 24'h000000, 6'b111111, 1'b0, 1'b0);
    for (int i = 0; i < 65535; i++) step(1'b1, 1'b0, i[7:0]);
    lit("count_ffff", 24'h00FFFF, 6'b111111, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'hFF);
    lit("count_wrap", 24'h000000, 6'b111111, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 8'h55);
    lit("err_sat", 24'hFF0000, 6'b111111, 1'b0, 1'b1);
    bus.show_count = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    lit("history_kept", 24'hFDFEFF, 6'b111111, 1'b0, 1'b1);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
